// File: rtl/tx_pkg.sv
// Shared constants and types for the transmit back end (tx_burst -> tx_dac_ramp).
package tx_pkg;

    localparam int TX_IN_WIDTH   = 9;
    localparam int TX_DAC_WIDTH  = 6;
    localparam int TX_RAMP_LOG2  = 4;
    localparam int DAC_MIDSCALE  = 1 << (TX_DAC_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAMP_UP,
        ST_ON,
        ST_RAMP_DOWN
    } tx_dac_state_t;

endpackage

// File: rtl/dac_requant.sv
// One DAC channel: offset-binary conversion, first-order error feedback with
// saturation, and the stage-2 output register.
module dac_requant
    import tx_pkg::*;
#(
    parameter int IN_WIDTH  = TX_IN_WIDTH,
    parameter int DAC_WIDTH = TX_DAC_WIDTH
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic                        clear,
    input  logic signed [IN_WIDTH-1:0]  scaled,
    output logic        [DAC_WIDTH-1:0] code
);

    localparam int ERR_WIDTH = IN_WIDTH - DAC_WIDTH;
    localparam logic [DAC_WIDTH-1:0] MID_CODE = {1'b1, {(DAC_WIDTH-1){1'b0}}};

    logic [ERR_WIDTH-1:0] err;
    logic [IN_WIDTH-1:0]  ob;
    logic [IN_WIDTH:0]    acc;

    // NOTE: every always_comb output is fully assigned on every path, so no latch is inferred.
    always_comb begin
        ob  = {~scaled[IN_WIDTH-1], scaled[IN_WIDTH-2:0]};
        acc = {1'b0, ob} + {{(DAC_WIDTH+1){1'b0}}, err};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            code <= MID_CODE;
            err  <= '0;
        end else begin
            if (enable) begin
                if (acc[IN_WIDTH]) begin
                    code <= '1;
                    err  <= '0;
                end else begin
                    code <= acc[IN_WIDTH-1:ERR_WIDTH];
                    err  <= acc[ERR_WIDTH-1:0];
                end
            end
            // Clearing overrides any shaper update in the same cycle.
            if (clear) begin
                err <= '0;
            end
        end
    end

endmodule

// File: rtl/tx_dac_ramp.sv
// Burst power ramp, sample hold and gain multiply feeding two noise-shaped
// 6-bit DAC channels; also drives the PA enable aligned with the codes.
module tx_dac_ramp
    import tx_pkg::*;
#(
    parameter int IN_WIDTH  = TX_IN_WIDTH,
    parameter int DAC_WIDTH = TX_DAC_WIDTH,
    parameter int RAMP_LOG2 = TX_RAMP_LOG2
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        sample_strobe,
    input  logic                        iq_valid,
    input  logic signed [IN_WIDTH-1:0]  inphase,
    input  logic signed [IN_WIDTH-1:0]  quadrature,
    output logic        [DAC_WIDTH-1:0] dac_i,
    output logic        [DAC_WIDTH-1:0] dac_q,
    output logic                        pa_en,
    output logic                        busy
);

    localparam int GW = RAMP_LOG2 + 1;
    localparam int PW = IN_WIDTH + RAMP_LOG2 + 1;
    localparam logic [GW-1:0] G_FULL = {1'b1, {RAMP_LOG2{1'b0}}};
    localparam logic [GW-1:0] G_LAST = {1'b0, {RAMP_LOG2{1'b1}}};

    tx_dac_state_t              state;
    logic [GW-1:0]              gain;
    logic signed [IN_WIDTH-1:0] hold_i, hold_q;
    logic signed [IN_WIDTH-1:0] s_i, s_q;
    logic                       stb_d1, stb_d2;
    logic                       pa_d1;
    logic                       idle;

    // Floor of x*g / 2**RAMP_LOG2; always fits back into IN_WIDTH signed.
    function automatic logic signed [IN_WIDTH-1:0] scale(
        input logic signed [IN_WIDTH-1:0] x,
        input logic        [GW-1:0]       g
    );
        return IN_WIDTH'((PW'(x) * $signed({{(PW-GW){1'b0}}, g})) >>> RAMP_LOG2);
    endfunction

    assign idle = (state == ST_IDLE);
    assign busy = !idle;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            gain   <= '0;
            hold_i <= '0;
            hold_q <= '0;
        end else begin
            if (sample_strobe && iq_valid) begin
                hold_i <= inphase;
                hold_q <= quadrature;
            end
            // iq_valid edges switch direction immediately; gain only moves on strobes.
            case (state)
                ST_IDLE: begin
                    gain <= '0;
                    if (iq_valid) state <= ST_RAMP_UP;
                end
                ST_RAMP_UP: begin
                    if (!iq_valid) begin
                        state <= ST_RAMP_DOWN;
                    end else if (sample_strobe) begin
                        gain <= gain + 1'b1;
                        if (gain == G_LAST) state <= ST_ON;
                    end
                end
                ST_ON: begin
                    gain <= G_FULL;
                    if (!iq_valid) state <= ST_RAMP_DOWN;
                end
                ST_RAMP_DOWN: begin
                    if (iq_valid) begin
                        state <= ST_RAMP_UP;
                    end else if (sample_strobe) begin
                        if (gain == '0) state <= ST_IDLE;
                        else            gain  <= gain - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stage 1: scaled sample (mid-scale while idle); strobe and PA enable ride alongside.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s_i    <= '0;
            s_q    <= '0;
            stb_d1 <= 1'b0;
            stb_d2 <= 1'b0;
            pa_d1  <= 1'b0;
            pa_en  <= 1'b0;
        end else begin
            s_i    <= idle ? '0 : scale(hold_i, gain);
            s_q    <= idle ? '0 : scale(hold_q, gain);
            stb_d1 <= sample_strobe;
            stb_d2 <= stb_d1;
            pa_d1  <= !idle;
            pa_en  <= pa_d1;
        end
    end

    dac_requant #(.IN_WIDTH(IN_WIDTH), .DAC_WIDTH(DAC_WIDTH)) u_req_i (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (stb_d2),
        .clear   (idle),
        .scaled  (s_i),
        .code    (dac_i)
    );

    dac_requant #(.IN_WIDTH(IN_WIDTH), .DAC_WIDTH(DAC_WIDTH)) u_req_q (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (stb_d2),
        .clear   (idle),
        .scaled  (s_q),
        .code    (dac_q)
    );

endmodule
